abs_delta_dec: RTL
==================

Name: abs_delta_dec

Overview:
- Reconstructs an 8-bit sample stream from a seed value followed by sign/magnitude deltas.
- Each delta is the |op1-op2| magnitude plus a direction bit, as produced by the subtract/absolute-difference path.
- This block is the receive/decode end of that path: new sample = previous sample ± magnitude.
- Ready/valid handshakes on both sides, with a registered output stage.

Parameters:
WIDTH, 8, sample and magnitude width in bits

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
seed_valid  input  1  loads seed_data as new base sample this cycle
seed_data  input  WIDTH  base sample value
in_valid  input  1  delta word present
in_ready  output  1  block accepts delta this cycle
in_mag  input  WIDTH  unsigned delta magnitude
in_neg  input  1  1: sample = base - mag; 0: sample = base + mag
out_valid  output  1  reconstructed sample held on out_data
out_ready  input  1  consumer accepts sample
out_data  output  WIDTH  reconstructed sample
out_ovf  output  1  sample went out of range (qualified by out_valid)

Behaviour:
- Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, base=0, out_valid=0, out_data=0, out_ovf=0. in_ready=0 while rst=1.
- States:
  - IDLE: no seed yet; in_ready=0; seed_valid=1 -> base<=seed_data, go to RUN.
  - RUN: deltas accepted; seed_valid=1 -> base<=seed_data, stay in RUN.
- Seed acceptance:
  - Unconditional; the seed never produces an output sample.
  - A pending out_valid/out_data is not disturbed by a seed.
- in_ready = (state==RUN) && !seed_valid && (!out_valid || out_ready). The signal is combinational from registers and inputs.
- Delta accept: in_valid && in_ready at edge N.
  - Compute sum = {1'b0,base} ± {1'b0,in_mag} at WIDTH+1 bits.
  - Result: out_data<=sum[WIDTH-1:0], base<=sum[WIDTH-1:0].
  - out_ovf <= carry (add) or borrow (sub).
  - out_valid<=1, visible in cycle N+1 (latency 1).
- Output hold:
  - While out_valid && !out_ready, out_data and out_ovf stay stable and in_ready=0.
  - out_valid clears at the edge where out_valid && out_ready && no new accept.
- Back-to-back: out_ready held 1 -> one sample per cycle, with accept and drain in the same edge.
- Simultaneous seed_valid and in_valid: the seed wins and the delta is not accepted (in_ready=0). The delta must be held by the source.
- Arithmetic: unsigned modulo 2^WIDTH (wrap) unless DELTA_SAT_EN.
- mag=0: output equals base, out_ovf=0.
- Reset mid-stream: any pending output is dropped and the block returns to IDLE, requiring a new seed.

Optional Feature:
- Macro: DELTA_SAT_EN
- Defined: on overflow out_data and base clamp to 2^WIDTH-1 (add) or 0 (sub); out_ovf still asserts.
- Undefined: wrap-around as above, with out_ovf flagging the wrap.

Test Plan:
1. Reset, then in_valid=1 with no seed -> in_ready=0, out_valid=0 for 10 cycles. Seed 200, then delta mag=77 neg=1 -> next cycle out_data=123, out_ovf=0.
2. Seed 123, deltas (77,+), (50,-), (0,+) with out_ready=1 -> out_data 200, 150, 150 on consecutive cycles.
3. Seed 250, delta (10,+):
   - without DELTA_SAT_EN -> out_data=4, out_ovf=1;
   - with DELTA_SAT_EN -> 255, out_ovf=1.
   Seed 5, delta (9,-) -> 252/ovf=1, or 0/ovf=1 with DELTA_SAT_EN.
4. Backpressure: out_ready=0 for 3 cycles after an output -> out_data stable, in_ready=0. out_ready=1 -> held sample drains and the next delta is accepted the same edge.
5. seed_valid=1 and in_valid=1 same cycle (seed 100, delta 20+) -> delta not accepted that cycle, accepted next -> out_data=120.
6. Assert rst while out_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=0 until re-seeded.

Source files
------------

// File: rtl/abs_delta_dec_if.sv
// rtl/abs_delta_dec_if.sv - seed, delta and sample handshake bundle for abs_delta_dec
interface abs_delta_dec_if #(
    parameter int WIDTH = 8
);
    logic             seed_valid;
    logic [WIDTH-1:0] seed_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mag;
    logic             in_neg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output seed_valid, seed_data, in_valid, in_mag, in_neg, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  seed_valid, seed_data, in_valid, in_mag, in_neg, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/abs_delta_dec.sv
// rtl/abs_delta_dec.sv - sign/magnitude delta decoder rebuilding samples from a seed
// Define DELTA_SAT_EN to clamp out-of-range samples instead of wrapping.
module abs_delta_dec #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    abs_delta_dec_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.seed_valid) begin
            state_next = RUN;
        end
    end

    // A seed in the same cycle pre-empts the delta, which the source must hold.
    always_comb begin
        bus.in_ready = 1'b0;
        if (!rst && state == RUN && !bus.seed_valid && (!bus.out_valid || bus.out_ready)) begin
            bus.in_ready = 1'b1;
        end
    end

    assign accept = bus.in_valid && bus.in_ready;

    // Extra top bit is the carry on add and the borrow on subtract.
    always_comb begin
        if (bus.in_neg) begin
            sum = {1'b0, base} - {1'b0, bus.in_mag};
        end else begin
            sum = {1'b0, base} + {1'b0, bus.in_mag};
        end
        ovf = sum[WIDTH];
`ifdef DELTA_SAT_EN
        if (ovf) begin
            result = bus.in_neg ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end else begin
            result = sum[WIDTH-1:0];
        end
`else
        result = sum[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ovf   <= 1'b0;
        end else begin
            if (bus.seed_valid) begin
                base <= bus.seed_data;
            end else if (accept) begin
                base <= result;
            end

            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= result;
                bus.out_ovf   <= ovf;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
